hwpe_ctrl_offload_master: RTL

// - Initiator side of the HWPE peripheral control protocol.
// - Takes job descriptors from a local source (core-side accelerator driver or DMA-less sequencer) and offloads each to an HWPE control slave:

---
 rtl/hwpe_ctrl_offload_master_pkg.sv | 26 ++
 rtl/hwpe_ctrl_offload_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_offload_master_pkg.sv
// Shared definitions for the HWPE control offload initiator: register indices and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hwpe_ctrl_offload_master_pkg;

    // Word indices of the HWPE control slave register file.
    localparam int unsigned REGFILE_IDX_TRIGGER   = 0;
    localparam int unsigned REGFILE_IDX_ACQUIRE   = 1;
    localparam int unsigned REGFILE_IDX_SOFTCLEAR = 5;
    localparam int unsigned REGFILE_IDX_SWEVT     = 7;

    typedef enum logic [2:0] {
        OFFLOAD_IDLE,
        OFFLOAD_ACQ,
        OFFLOAD_ACQ_RSP,
        OFFLOAD_BACKOFF,
        OFFLOAD_WRITE,
        OFFLOAD_TRIG
    } offload_state_t;

    // The peripheral bus is byte addressed; registers are 32-bit words.
    function automatic logic [31:0] reg_byte_addr(input logic [29:0] reg_idx);
        return {reg_idx, 2'b00};
    endfunction

endpackage

// File: rtl/hwpe_ctrl_offload_master.sv
// Initiator of the HWPE peripheral control protocol: acquire context, write job words, trigger, track done events.
// Latency: accept at T -> acquire req T+1, writes T+3.., trigger T+3+N_JOB_REGS (gnt=1, 1-cycle r_valid).
// Backpressure: job_ready_o low while busy or N_CONTEXT jobs in flight; bus requests hold until periph_gnt_i.
//
// Ports:
//   clk_i, rst_ni, clear_i          clock, async active-low reset, synchronous soft clear
//   job_valid_i/job_ready_o         job descriptor handshake; job_regs_i latched on accept
//   job_done_o, inflight_o          per-job done pulse, count of triggered-but-not-done jobs
//   busy_o, err_o                   FSM active; sticky error (retry abort or spurious done)
//   evt_done_i                      done event from the slave for this core
//   periph_*                        HWPE peripheral (TCDM-like) initiator port
module hwpe_ctrl_offload_master
    import hwpe_ctrl_offload_master_pkg::*;
#(
    parameter int unsigned N_CONTEXT      = 2,
    parameter int unsigned N_JOB_REGS     = 4,
    parameter int unsigned JOB_REG_BASE   = 8,
    parameter int unsigned CORE_ID        = 0,
    parameter int unsigned ID_WIDTH       = 16,
    parameter int unsigned BACKOFF_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               job_valid_i,
    output logic                               job_ready_o,
    input  logic [N_JOB_REGS-1:0][31:0]        job_regs_i,
    output logic                               job_done_o,
    output logic [$clog2(N_CONTEXT+1)-1:0]     inflight_o,
    output logic                               busy_o,
    output logic                               err_o,
    input  logic                               evt_done_i,
    output logic                               periph_req_o,
    output logic [31:0]                        periph_add_o,
    output logic                               periph_wen_o,
    output logic [3:0]                         periph_be_o,
    output logic [31:0]                        periph_data_o,
    output logic [ID_WIDTH-1:0]                periph_id_o,
    input  logic                               periph_gnt_i,
    input  logic [31:0]                        periph_r_data_i,
    input  logic                               periph_r_valid_i
);

    localparam int unsigned INFL_W = $clog2(N_CONTEXT + 1);
    localparam int unsigned IDX_W  = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam int unsigned BO_W   = $clog2(BACKOFF_CYCLES + 1);

    localparam logic [INFL_W-1:0]   INFL_MAX   = INFL_W'(N_CONTEXT);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_JOB_REGS - 1);
    localparam logic [BO_W-1:0]     BO_LAST    = BO_W'(BACKOFF_CYCLES - 1);
    localparam logic [15:0]         RETRY_MAX  = 16'(MAX_RETRIES);
    localparam logic [ID_WIDTH-1:0] ID_ONEHOT  = ID_WIDTH'(1) << CORE_ID;

    offload_state_t                  state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [BO_W-1:0]                 bo_cnt_q, bo_cnt_d;
    logic [15:0]                     retry_q, retry_d;
    logic [INFL_W-1:0]               inflight_q, inflight_d;
    logic                            err_q, err_d;
    logic                            done_q, done_d;
    logic [N_JOB_REGS-1:0][31:0]     job_buf_q, job_buf_d;

    logic job_accept;
    logic trig_fire;
    logic err_set;
    logic evt_ok;
    logic unused_rdata;

    // Only the "no free context" flag of the acquire response matters here.
    assign unused_rdata = ^periph_r_data_i[30:0];

    // Gated by rst_ni so no job is offered while the block is held in reset.
    assign job_ready_o = rst_ni & (state_q == OFFLOAD_IDLE) & (inflight_q < INFL_MAX) & ~clear_i;
    assign job_accept  = job_valid_i & job_ready_o;

    assign busy_o      = (state_q != OFFLOAD_IDLE);
    assign err_o       = err_q;
    assign job_done_o  = done_q;
    assign inflight_o  = inflight_q;
    assign periph_be_o = periph_req_o ? 4'hF : 4'h0;
    assign periph_id_o = periph_req_o ? ID_ONEHOT : '0;

    // Main offload FSM: drives the bus from state only, so request fields are
    // naturally stable until the grant moves the FSM on.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        bo_cnt_d      = bo_cnt_q;
        retry_d       = retry_q;
        job_buf_d     = job_buf_q;
        trig_fire     = 1'b0;
        err_set       = 1'b0;
        periph_req_o  = 1'b0;
        periph_add_o  = 32'h0;
        periph_wen_o  = 1'b0;
        periph_data_o = 32'h0;

        unique case (state_q)
            OFFLOAD_IDLE: begin
                if (job_accept) begin
                    job_buf_d = job_regs_i;
                    retry_d   = '0;
                    state_d   = OFFLOAD_ACQ;
                end
            end
            OFFLOAD_ACQ: begin
                periph_req_o = 1'b1;
                periph_add_o = reg_byte_addr(30'(REGFILE_IDX_ACQUIRE));
                periph_wen_o = 1'b1;
                if (periph_gnt_i) begin
                    state_d = OFFLOAD_ACQ_RSP;
                end
            end
            OFFLOAD_ACQ_RSP: begin
                if (periph_r_valid_i) begin
                    if (periph_r_data_i[31]) begin
                        // Slave has no free context: wait, then retry.
                        state_d  = OFFLOAD_BACKOFF;
                        bo_cnt_d = '0;
                        if (retry_q != 16'hFFFF) begin
                            retry_d = retry_q + 16'd1;
                        end
                    end else begin
                        state_d = OFFLOAD_WRITE;
                        idx_d   = '0;
                        retry_d = '0;
                    end
                end
            end
            OFFLOAD_BACKOFF: begin
                // Abort is decided on the first backoff cycle, so the last
                // failed acquire is not followed by a pointless wait.
                if ((RETRY_MAX != 16'd0) && (retry_q == RETRY_MAX)) begin
                    err_set = 1'b1;
                    retry_d = '0;
                    state_d = OFFLOAD_IDLE;
                end else if (bo_cnt_q == BO_LAST) begin
                    state_d = OFFLOAD_ACQ;
                end else begin
                    bo_cnt_d = bo_cnt_q + 1'b1;
                end
            end
            OFFLOAD_WRITE: begin
                periph_req_o  = 1'b1;
                periph_add_o  = reg_byte_addr(30'(JOB_REG_BASE) + 30'(idx_q));
                periph_data_o = job_buf_q[idx_q];
                if (periph_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = OFFLOAD_TRIG;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            OFFLOAD_TRIG: begin
                periph_req_o = 1'b1;
                periph_add_o = reg_byte_addr(30'(REGFILE_IDX_TRIGGER));
                if (periph_gnt_i) begin
                    trig_fire = 1'b1;
                    state_d   = OFFLOAD_IDLE;
                end
            end
            default: begin
                state_d = OFFLOAD_IDLE;
            end
        endcase

        if (clear_i) begin
            state_d   = OFFLOAD_IDLE;
            idx_d     = '0;
            bo_cnt_d  = '0;
            retry_d   = '0;
            job_buf_d = '0;
        end
    end

    // In-flight bookkeeping. A done event is legitimate if a job is already
    // in flight or one is being triggered in the same cycle.
    always_comb begin
        inflight_d = inflight_q;
        evt_ok     = evt_done_i & ((inflight_q != '0) | trig_fire);
        done_d     = evt_ok;
        err_d      = err_q | err_set | (evt_done_i & ~evt_ok);

        unique case ({trig_fire, evt_ok})
            2'b10: begin
                if (inflight_q != INFL_MAX) begin
                    inflight_d = inflight_q + 1'b1;
                end
            end
            2'b01: begin
                inflight_d = inflight_q - 1'b1;
            end
            default: begin
                inflight_d = inflight_q;
            end
        endcase

        if (clear_i) begin
            inflight_d = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OFFLOAD_IDLE;
            idx_q      <= '0;
            bo_cnt_q   <= '0;
            retry_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            job_buf_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bo_cnt_q   <= bo_cnt_d;
            retry_q    <= retry_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            done_q     <= done_d;
            job_buf_q  <= job_buf_d;
        end
    end

endmodule
